// File: rtl/filt_tile_writer.sv
// Filter tile writer: accepts an address-tagged filter word stream for one (k, c) tile,
// checks each tag against the walk order and writes words to sequential local addresses.
module filt_tile_writer #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 31,
   parameter int LADDR_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [DATA_WIDTH-1:0]  C,
   input  logic [DATA_WIDTH-1:0]  R,
   input  logic [DATA_WIDTH-1:0]  S,
   input  logic [DATA_WIDTH-1:0]  Tk,
   input  logic [DATA_WIDTH-1:0]  Tc,
   input  logic [DATA_WIDTH-1:0]  ko,
   input  logic [DATA_WIDTH-1:0]  co,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDR_WIDTH:0]    in_addr,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   buf_we,
   output logic [LADDR_WIDTH-1:0] buf_addr,
   output logic [DATA_WIDTH-1:0]  buf_wdata,
   output logic                   busy,
   output logic                   done,
   output logic                   addr_err,
   output logic [1:0]             fsm_state
);

   localparam int AW1 = ADDR_WIDTH + 1;
   localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

   state_t state, next_state;

   logic [DATA_WIDTH-1:0]  cfg_c, cfg_r, cfg_s, cfg_tk, cfg_tc, cfg_ko, cfg_co;
   logic [DATA_WIDTH-1:0]  k_cnt, c_cnt, r_cnt, s_cnt;
   logic [LADDR_WIDTH-1:0] lidx;
   logic [ADDR_WIDTH:0]    exp_addr;
   logic                   accept, cfg_zero;
   logic                   last_s, last_r, last_c, last_k, last_word;

   // Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1;
   // in_ready depends only on state, never on in_valid.

   // Truncation commutes with + and *, so evaluating at the address width gives the
   // low bits of the full-width product exactly.
   assign exp_addr = ((AW1'(k_cnt) * AW1'(cfg_c) + AW1'(c_cnt)) * AW1'(cfg_r)
                      + AW1'(r_cnt)) * AW1'(cfg_s) + AW1'(s_cnt);

   assign cfg_zero  = (Tk == '0) || (Tc == '0) || (R == '0) || (S == '0);
   assign last_s    = (s_cnt == cfg_s - ONE_D);
   assign last_r    = (r_cnt == cfg_r - ONE_D);
   assign last_c    = (c_cnt == cfg_co + cfg_tc - ONE_D);
   assign last_k    = (k_cnt == cfg_ko + cfg_tk - ONE_D);
   assign last_word = last_s && last_r && last_c && last_k;
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      in_ready   = 1'b0;
      busy       = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) next_state = cfg_zero ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            accept   = in_valid;
            if (in_valid && last_word) next_state = ST_DONE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_c     <= '0;
         cfg_r     <= '0;
         cfg_s     <= '0;
         cfg_tk    <= '0;
         cfg_tc    <= '0;
         cfg_ko    <= '0;
         cfg_co    <= '0;
         k_cnt     <= '0;
         c_cnt     <= '0;
         r_cnt     <= '0;
         s_cnt     <= '0;
         lidx      <= '0;
         buf_we    <= 1'b0;
         buf_addr  <= '0;
         buf_wdata <= '0;
         done      <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         buf_we <= accept;
         if (start && state != ST_RUN) begin
            cfg_c    <= C;
            cfg_r    <= R;
            cfg_s    <= S;
            cfg_tk   <= Tk;
            cfg_tc   <= Tc;
            cfg_ko   <= ko;
            cfg_co   <= co;
            k_cnt    <= ko;
            c_cnt    <= co;
            r_cnt    <= '0;
            s_cnt    <= '0;
            lidx     <= '0;
            addr_err <= 1'b0;
            done     <= cfg_zero;
         end else if (accept) begin
            buf_addr  <= lidx;
            buf_wdata <= in_data;
            lidx      <= lidx + LADDR_WIDTH'(1);
            if (in_addr != exp_addr) addr_err <= 1'b1;
            if (last_word) done <= 1'b1;
            // Walk order: s fastest, then r, then c within the tile, then k.
            if (!last_s) begin
               s_cnt <= s_cnt + ONE_D;
            end else begin
               s_cnt <= '0;
               if (!last_r) begin
                  r_cnt <= r_cnt + ONE_D;
               end else begin
                  r_cnt <= '0;
                  if (!last_c) begin
                     c_cnt <= c_cnt + ONE_D;
                  end else begin
                     c_cnt <= cfg_co;
                     k_cnt <= k_cnt + ONE_D;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_filt_tile_writer.sv
// Bench for filt_tile_writer: directed corner sequences plus a table of tile shapes,
// each checked against an address list built from nested loops over k, c, r, s.
module tb_filt_tile_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] C, R, S, Tk, Tc, ko, co;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [15:0] in_data;
   logic        buf_we;
   logic [15:0] buf_addr;
   logic [15:0] buf_wdata;
   logic        busy, done, addr_err;
   logic [1:0]  fsm_state;

   filt_tile_writer dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .C(C), .R(R), .S(S), .Tk(Tk), .Tc(Tc), .ko(ko), .co(co),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
      .busy(busy), .done(done), .addr_err(addr_err), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int c, r, s, tk, tc, ko, co;
   } cfg_t;

   typedef struct {
      cfg_t cfg;
      int   words;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          wr_cnt   = 0;
   bit          err_seen = 0;
   logic [31:0] mdl_addr[$];
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every tile word in walk order, address computed from the definition.
   task automatic build_model(input cfg_t cf);
      longint unsigned a;
      mdl_addr.delete();
      for (longint unsigned kk = cf.ko; kk < cf.ko + cf.tk; kk++)
         for (longint unsigned cc = cf.co; cc < cf.co + cf.tc; cc++)
            for (longint unsigned rr = 0; rr < cf.r; rr++)
               for (longint unsigned ss = 0; ss < cf.s; ss++) begin
                  a = ((kk * cf.c + cc) * cf.r + rr) * cf.s + ss;
                  mdl_addr.push_back(a[31:0]);
               end
   endtask

   task automatic do_start(input cfg_t cf, input bit ignored);
      @(posedge clk); #1;
      C  = cf.c[15:0];  R  = cf.r[15:0];  S  = cf.s[15:0];
      Tk = cf.tk[15:0]; Tc = cf.tc[15:0]; ko = cf.ko[15:0]; co = cf.co[15:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (!ignored) begin
         wr_cnt   = 0;
         err_seen = 0;
         build_model(cf);
      end
   endtask

   // Drive words first..last-1 of the model; prob is the percent chance of in_valid per cycle.
   task automatic feed(input int first, input int last, input int prob, input int bad);
      int idx   = first;
      int guard = 0;
      while (idx < last && guard < 4000) begin
         in_valid = ($urandom_range(0, 99) < prob);
         in_addr  = (idx == bad) ? ~mdl_addr[idx] : mdl_addr[idx];
         in_data  = 16'($urandom);
         chk("in_ready_run", 64'(in_ready), 64'(1));
         chk("busy_run", 64'(busy), 64'(1));
         @(posedge clk); #1;
         if (in_valid) begin
            exp_q.push_back({idx[15:0], in_data});
            if (idx == bad) err_seen = 1;
            idx++;
            chk("addr_err", 64'(addr_err), 64'(err_seen));
            chk("done_timing", 64'(done), 64'(idx == mdl_addr.size()));
         end
         guard++;
      end
      in_valid = 1'b0;
      if (guard >= 4000) chk("feed_timeout", 64'(idx), 64'(last));
   endtask

   task automatic finish_tile(input int words);
      in_valid = 1'b1;
      in_addr  = 32'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("in_ready_done", 64'(in_ready), 64'(0));
      end
      in_valid = 1'b0;
      @(negedge clk); #1;
      chk("write_count", 64'(wr_cnt), 64'(words));
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      chk("done_held", 64'(done), 64'(1));
      chk("busy_done", 64'(busy), 64'(0));
      chk("addr_err_end", 64'(addr_err), 64'(err_seen));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
      chk({tag, "_buf_we"}, 64'(buf_we), 64'(0));
      chk({tag, "_buf_addr"}, 64'(buf_addr), 64'(0));
      chk({tag, "_buf_wdata"}, 64'(buf_wdata), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_addr_err"}, 64'(addr_err), 64'(0));
   endtask

   // Scoreboard: each write must match the oldest accepted word.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && buf_we) begin
         chk("write_expected", 64'(exp_q.size() > 0), 64'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("buf_addr", 64'(buf_addr), 64'(e[31:16]));
            chk("buf_wdata", 64'(buf_wdata), 64'(e[15:0]));
         end
         wr_cnt++;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      cfg_t base, zero_tc;
      base    = '{c: 4, r: 3, s: 3, tk: 2, tc: 2, ko: 1, co: 2};
      zero_tc = '{c: 4, r: 3, s: 3, tk: 2, tc: 0, ko: 1, co: 2};
      vecs[0] = '{cfg: base, words: 36};
      vecs[1] = '{cfg: '{c: 1, r: 1, s: 1, tk: 1, tc: 1, ko: 0, co: 0}, words: 1};
      vecs[2] = '{cfg: '{c: 3, r: 2, s: 5, tk: 1, tc: 3, ko: 2, co: 0}, words: 30};
      vecs[3] = '{cfg: '{c: 2, r: 1, s: 4, tk: 3, tc: 1, ko: 0, co: 1}, words: 12};
      vecs[4] = '{cfg: '{c: 65535, r: 3, s: 3, tk: 1, tc: 1, ko: 65535, co: 65534}, words: 9};
      vecs[5] = '{cfg: '{c: 4, r: 0, s: 3, tk: 2, tc: 2, ko: 0, co: 0}, words: 0};
      vecs[6] = '{cfg: '{c: 4, r: 3, s: 3, tk: 0, tc: 2, ko: 0, co: 0}, words: 0};

      // Clock/reset
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
      C = '0; R = '0; S = '0; Tk = '0; Tc = '0; ko = '0; co = '0;
      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Full tile, in_valid held high, correct tags
      do_start(base, 0);
      feed(0, 36, 100, -1);
      finish_tile(36);

      // Same tile with random stalls
      do_start(base, 0);
      feed(0, 36, 50, -1);
      finish_tile(36);

      // Word 5 carries a wrong tag
      do_start(base, 0);
      feed(0, 36, 70, 5);
      finish_tile(36);

      // Zero tile depth: straight to DONE
      do_start(zero_tc, 0);
      chk("tc0_done", 64'(done), 64'(1));
      chk("tc0_busy", 64'(busy), 64'(0));
      chk("tc0_ready", 64'(in_ready), 64'(0));
      finish_tile(0);

      // Reset in mid-tile, then replay from local address 0
      do_start(base, 0);
      feed(0, 10, 100, -1);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("idle_after_reset", 64'(busy), 64'(0));
      do_start(base, 0);
      feed(0, 36, 80, -1);
      finish_tile(36);

      // Start during RUN is ignored; start in DONE restarts
      do_start(base, 0);
      feed(0, 5, 100, -1);
      do_start(zero_tc, 1);
      chk("start_ignored_busy", 64'(busy), 64'(1));
      chk("start_ignored_done", 64'(done), 64'(0));
      feed(5, 36, 60, -1);
      finish_tile(36);
      do_start(base, 0);
      chk("restart_done_clear", 64'(done), 64'(0));
      chk("restart_busy", 64'(busy), 64'(1));
      feed(0, 36, 60, -1);
      finish_tile(36);

      // Table of tile shapes with random stalls
      for (int v = 0; v < 7; v++) begin
         do_start(vecs[v].cfg, 0);
         feed(0, mdl_addr.size(), 65, -1);
         finish_tile(vecs[v].words);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/filt_tile_writer.md
FILT_TILE_WRITER -- requirements
Module: filt_tile_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of configuration fields and data words.
REQ-002 Parameter ADDR_WIDTH, default 31: global filter address is ADDR_WIDTH+1 bits wide.
REQ-003 Parameter LADDR_WIDTH, default 16: width of the local tile-buffer address.
REQ-004 Port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  one-cycle request to latch the configuration and begin a tile.
REQ-007 Ports C, R, S, Tk, Tc, ko, co  input  DATA_WIDTH each  total input maps, filter rows, filter columns, tile output maps, tile input maps, tile start k, tile start c.
REQ-008 Port in_valid  input  1  an incoming filter word is present.
REQ-009 Port in_ready  output  1  the block accepts the word this cycle.
REQ-010 Port in_addr  input  ADDR_WIDTH+1  global filter address tagged on the word.
REQ-011 Port in_data  input  DATA_WIDTH  filter word.
REQ-012 Port buf_we  output  1  tile-buffer write strobe.
REQ-013 Port buf_addr  output  LADDR_WIDTH  tile-local write address.
REQ-014 Port buf_wdata  output  DATA_WIDTH  tile-buffer write data.
REQ-015 Ports busy, done, addr_err  output  1 each  tile in progress, tile complete, address mismatch seen.

Function
REQ-016 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-017 In IDLE or DONE, start=1 SHALL latch all seven configuration inputs, set k=ko, c=co, r=0, s=0, local index=0, clear addr_err and done, and enter RUN.
REQ-018 If any latched value among Tk, Tc, R, S is zero, start SHALL go directly to DONE with no writes.
REQ-019 start SHALL be ignored while in RUN.
REQ-020 in_ready SHALL be 1 exactly when the state is RUN; a word is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-021 The expected address SHALL be ((k*C+c)*R+r)*S+s, computed at the full product width and truncated to ADDR_WIDTH+1 bits.
REQ-022 On acceptance, on the next cycle the block SHALL drive buf_we=1 with buf_addr equal to the local index (truncated to LADDR_WIDTH) and buf_wdata equal to the accepted in_data.
REQ-023 buf_we SHALL be 0 on every cycle not following an acceptance, and buf_we SHALL deassert on the following cycle.
REQ-024 On acceptance, if in_addr differs from the expected address, addr_err SHALL be set on the next cycle and held until the next start or reset; the word is still written.
REQ-025 On acceptance, the counters SHALL advance in this order: s first, then r, then c, then k. s wraps at S to 0 and increments r; r wraps at R and increments c; c wraps at co+Tc back to co and increments k. The local index increments by 1.
REQ-026 Acceptance of the word with k=ko+Tk-1, c=co+Tc-1, r=R-1, s=S-1 SHALL move the state to DONE, and done SHALL rise on the same cycle as the final buf_we.
REQ-027 done SHALL hold at 1 in DONE until the next start or reset.
REQ-028 busy SHALL equal 1 exactly in RUN.
REQ-029 No words are accepted outside RUN; in_valid stalls of any length in RUN SHALL leave all counters unchanged.
REQ-030 Tiles larger than 2^LADDR_WIDTH words SHALL wrap the local address modulo 2^LADDR_WIDTH.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, in_ready=0, buf_we=0, buf_addr=0, buf_wdata=0, busy=0, done=0, addr_err=0, and all counters to 0, regardless of clock.
REQ-032 Reset asserted mid-tile SHALL abandon the tile; after release, the block SHALL wait in IDLE for start.

Verification
REQ-033 Configuration C=4, R=3, S=3, Tk=2, Tc=2, ko=1, co=2, with 36 words carrying correct addresses and in_valid held high. Required: buf_addr runs 0..35, the first expected address is 54, done=1 with the 36th buf_we, and addr_err=0.
REQ-034 Same configuration with in_valid toggling randomly. Required: identical write sequence, no duplicated or skipped buf_addr, and in_ready=1 throughout RUN.
REQ-035 Word 5 is tagged with a wrong address. Required: addr_err rises the cycle after its acceptance, stays high, and all 36 writes still occur.
REQ-036 start with Tc=0. Required: DONE on the next cycle, zero buf_we pulses, and in_ready stays 0.
REQ-037 rst_n pulsed low after 10 accepted words. Required: all outputs are 0 immediately; a subsequent start replays from buf_addr 0.
REQ-038 start pulsed during RUN, then a second start in DONE. Required: the first start is ignored; the second clears done and restarts the tile.
